// File: rtl/micro_sequencer_if.sv
// Signal bundle between the micro-sequencer, the microcode ROM, the CPU bus and the register file.
// The master modport is the sequencer side. The slave modport is everything around it.
interface micro_sequencer_if #(
  parameter int NREGS = 8
);
  logic [15:0]      bus;
  logic [15:0]      uinstr;
  logic             ready;
  logic [10:0]      uaddr;
  logic [7:0]       opcode;
  logic [2:0]       tstate;
  logic [NREGS-1:0] load_bar;
  logic [2:0]       bus_sel;
  logic             bus_en_bar;
  logic [4:0]       aux;
  logic             halted;

  modport master (
    input  bus, uinstr, ready,
    output uaddr, opcode, tstate, load_bar, bus_sel, bus_en_bar, aux, halted
  );

  modport slave (
    output bus, uinstr, ready,
    input  uaddr, opcode, tstate, load_bar, bus_sel, bus_en_bar, aux, halted
  );
endinterface

// File: rtl/micro_sequencer.sv
// Control-unit front end: instruction register, T-state counter and microinstruction decode.
// Load strobes are combinational from uinstr, so registers load on the same edge that advances tstate.
module micro_sequencer #(
  parameter int NSTEPS = 8,
  parameter int NREGS  = 8
) (
  input  logic               clk,
  input  logic               reset_bar,
  micro_sequencer_if.master  sif
);
  localparam logic [2:0] LAST_STEP = 3'(NSTEPS - 1);

  typedef enum logic {ST_RUN, ST_HALT} state_t;

  state_t           state_reg, state_next;
  logic [2:0]       tstate_reg, tstate_next;
  logic [7:0]       opcode_reg, opcode_next;
  logic [NREGS-1:0] strobe_n;

  logic       rt, halt, irl, be, le;
  logic [2:0] load_sel;
  logic       halted, active;

  assign rt       = sif.uinstr[15];
  assign halt     = sif.uinstr[14];
  assign irl      = sif.uinstr[13];
  assign be       = sif.uinstr[9];
  assign le       = sif.uinstr[8];
  assign load_sel = sif.uinstr[7:5];

  assign halted = (state_reg == ST_HALT);
  assign active = reset_bar & ~halted & sif.ready;

  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      state_reg  <= ST_RUN;
      tstate_reg <= 3'd0;
      opcode_reg <= 8'h00;
    end else begin
      state_reg  <= state_next;
      tstate_reg <= tstate_next;
      opcode_reg <= opcode_next;
    end
  end

  // HALT freezes tstate even when RT or the wrap point coincide; IRL still loads.
  always_comb begin
    state_next  = state_reg;
    tstate_next = tstate_reg;
    opcode_next = opcode_reg;
    if (active) begin
      if (irl)
        opcode_next = sif.bus[15:8];
      if (halt)
        state_next = ST_HALT;
      else if (rt || tstate_reg == LAST_STEP)
        tstate_next = 3'd0;
      else
        tstate_next = tstate_reg + 3'd1;
    end
  end

  // If-based decode: an unknown uinstr or ready falls to the all-ones default, never to a multi-hot strobe.
  always_comb begin
    strobe_n = '1;
    if (active && le) begin
      for (int i = 0; i < NREGS; i++) begin
        if (load_sel == 3'(i))
          strobe_n[i] = 1'b0;
      end
    end
  end

  assign sif.load_bar   = strobe_n;
  assign sif.bus_en_bar = ~(reset_bar & ~halted & be);
  assign sif.bus_sel    = sif.uinstr[12:10];
  assign sif.aux        = sif.uinstr[4:0];
  assign sif.uaddr      = {opcode_reg, tstate_reg};
  assign sif.opcode     = opcode_reg;
  assign sif.tstate     = tstate_reg;
  assign sif.halted     = halted;
endmodule

// File: tb/tb_micro_sequencer.sv
// Randomised scoreboard bench for micro_sequencer.
// It runs an 8-register instance and a 4-register instance side by side.
module tb_micro_sequencer;
  localparam int NSTEPS = 8;

  logic clk = 1'b0;
  logic reset_bar;
  always #5 clk = ~clk;

  micro_sequencer_if #(.NREGS(8)) sif8 ();
  micro_sequencer_if #(.NREGS(4)) sif4 ();

  micro_sequencer #(.NSTEPS(NSTEPS), .NREGS(8)) u_dut8 (
    .clk       (clk),
    .reset_bar (reset_bar),
    .sif       (sif8)
  );

  micro_sequencer #(.NSTEPS(NSTEPS), .NREGS(4)) u_dut4 (
    .clk       (clk),
    .reset_bar (reset_bar),
    .sif       (sif4)
  );

  typedef struct {
    int          id;
    logic [7:0]  lb;
    logic [3:0]  lb4;
    logic        ben;
    logic [2:0]  bs;
    logic [4:0]  aux;
    logic [10:0] ua;
    logic [7:0]  op;
    logic [2:0]  ts;
    logic        h;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   txn      = 0;

  // Reference state kept as plain integers.
  int m_t  = 0;
  int m_op = 0;
  bit m_h  = 0;

  function automatic logic [15:0] strobe_mask(input int nregs, input logic [15:0] ui, input bit act);
    logic [15:0] m;
    int sel;
    m   = '1;
    sel = int'(ui[7:5]);
    if (act && ui[8] && sel < nregs)
      m[sel] = 1'b0;
    return m;
  endfunction

  task automatic step(input logic rb, input logic [15:0] ui, input logic [15:0] b, input logic rdy);
    exp_t e;
    logic [15:0] m8, m4;
    bit act;
    @(posedge clk);
    #1;
    reset_bar   = rb;
    sif8.uinstr = ui;  sif8.bus = b;  sif8.ready = rdy;
    sif4.uinstr = ui;  sif4.bus = b;  sif4.ready = rdy;
    if (!rb) begin
      m_t = 0; m_op = 0; m_h = 0;
    end
    act   = rb && !m_h && rdy;
    m8    = strobe_mask(8, ui, act);
    m4    = strobe_mask(4, ui, act);
    e.id  = txn;
    e.lb  = m8[7:0];
    e.lb4 = m4[3:0];
    e.ben = !(rb && !m_h && ui[9]);
    e.bs  = ui[12:10];
    e.aux = ui[4:0];
    e.ua  = 11'(m_op * 8 + m_t);
    e.op  = 8'(m_op);
    e.ts  = 3'(m_t);
    e.h   = m_h;
    exp_q.push_back(e);
    txn++;
    // State change for the coming rising edge.
    if (rb && act) begin
      if (ui[13]) m_op = int'(b[15:8]);
      if (ui[14]) m_h = 1;
      else if (ui[15]) m_t = 0;
      else m_t = (m_t + 1) % NSTEPS;
    end
  endtask

  task automatic cmp(input string name, input int id, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL txn %0d %s: got %h expected %h", id, name, act, req);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp("load_bar",   e.id, 16'(sif8.load_bar),   16'(e.lb));
        cmp("load_bar4",  e.id, 16'(sif4.load_bar),   16'(e.lb4));
        cmp("bus_en_bar", e.id, 16'(sif8.bus_en_bar), 16'(e.ben));
        cmp("bus_sel",    e.id, 16'(sif8.bus_sel),    16'(e.bs));
        cmp("aux",        e.id, 16'(sif8.aux),        16'(e.aux));
        cmp("uaddr",      e.id, 16'(sif8.uaddr),      16'(e.ua));
        cmp("opcode",     e.id, 16'(sif8.opcode),     16'(e.op));
        cmp("tstate",     e.id, 16'(sif8.tstate),     16'(e.ts));
        cmp("halted",     e.id, 16'(sif8.halted),     16'(e.h));
        cmp("tstate4",    e.id, 16'(sif4.tstate),     16'(e.ts));
        $display("txn %0d ts=%0d op=%h ua=%h lb=%h ben=%b h=%b", e.id,
                 sif8.tstate, sif8.opcode, sif8.uaddr, sif8.load_bar, sif8.bus_en_bar, sif8.halted);
      end
    end
  end

  initial begin
    logic [15:0] ui;
    reset_bar   = 1'b0;
    sif8.uinstr = '0; sif8.bus = '0; sif8.ready = 1'b1;
    sif4.uinstr = '0; sif4.bus = '0; sif4.ready = 1'b1;

    // Reset with a strobe-requesting word present, then a free-running count with wrap.
    repeat (3) step(1'b0, 16'h01FF, 16'h0000, 1'b1);
    repeat (10) step(1'b1, 16'h0000, 16'h0000, 1'b1);

    // Fetch: IRL at tstate 0, then RT at tstate 1.
    step(1'b0, 16'h0000, 16'h0000, 1'b1);
    step(1'b1, 16'h2000, 16'hA53C, 1'b1);
    step(1'b1, 16'h8000, 16'h0000, 1'b1);
    step(1'b1, 16'h0000, 16'h0000, 1'b1);
    step(1'b1, 16'hA000, 16'h3C00, 1'b1);
    step(1'b1, 16'h0000, 16'h0000, 1'b1);

    // Strobe decode, including load_sel above the 4-register instance.
    step(1'b1, 16'h0360, 16'h0000, 1'b1);
    step(1'b1, 16'h03E0, 16'h0000, 1'b1);
    step(1'b1, 16'h1D1F, 16'h0000, 1'b1);

    // Stall at tstate 2 with LE set, then release.
    step(1'b0, 16'h0000, 16'h0000, 1'b1);
    repeat (2) step(1'b1, 16'h0000, 16'h0000, 1'b1);
    step(1'b1, 16'h0360, 16'h0000, 1'b0);
    step(1'b1, 16'h0160, 16'h0000, 1'b0);
    step(1'b1, 16'h0360, 16'h0000, 1'b0);
    step(1'b1, 16'h0360, 16'h0000, 1'b1);
    step(1'b1, 16'h0000, 16'h0000, 1'b1);

    // Halt at tstate 4 with IRL, then LE words that must not strobe, then async reset pulse.
    step(1'b0, 16'h0000, 16'h0000, 1'b1);
    repeat (4) step(1'b1, 16'h0000, 16'h0000, 1'b1);
    step(1'b1, 16'hE000, 16'h7700, 1'b1);
    repeat (12) begin
      ui = 16'($urandom) | 16'h0100;
      step(1'b1, ui, 16'($urandom), 1'($urandom));
    end
    step(1'b0, 16'h0360, 16'h0000, 1'b1);
    step(1'b1, 16'h0000, 16'h0000, 1'b1);

    // Randomised traffic: occasional halts, resets and stalls.
    repeat (300) begin
      ui = 16'($urandom);
      if ($urandom_range(0, 39) != 0) ui[14] = 1'b0;
      if ($urandom_range(0, 3) != 0)  ui[15] = 1'b0;
      step(($urandom_range(0, 29) != 0), ui, 16'($urandom), ($urandom_range(0, 4) != 0));
    end

    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
